// File: rtl/alu_wide_seq.sv
// Multi-byte sequencer that drives an 8-bit ALU one byte per cycle, LSB first.
// Optional ALU_WIDE_SEQ_ABORT_EN adds an Abort input that cancels an operation in flight.
module alu_wide_seq #(
    parameter  int NBYTES = 2,
    localparam int W      = 8 * NBYTES
) (
    input  logic         CLK,
    input  logic         RST,
`ifdef ALU_WIDE_SEQ_ABORT_EN
    input  logic         Abort,
`endif
    input  logic         Start,
    input  logic         Mode,
    input  logic [3:0]   Selector,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         CarryIn,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] F,
    output logic         CarryOut,
    output logic         ZeroFlag,
    output logic         AluMode,
    output logic [3:0]   AluSel,
    output logic [7:0]   AluA,
    output logic [7:0]   AluB,
    output logic         AluCin,
    input  logic [7:0]   AluF,
    input  logic         AluCout
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic           lat_mode;
    logic [3:0]     lat_sel;
    logic [W-1:0]   lat_a;
    logic [W-1:0]   lat_b;
    logic           chain_carry;
    logic [W-1:0]   stage;
    logic [W-1:0]   merged;

    // Outside EXEC the ALU sees the idle pattern; merged is the staging value with this cycle's slice inserted.
    always_comb begin
        AluMode = 1'b1;
        AluSel  = 4'h0;
        AluA    = 8'h00;
        AluB    = 8'h00;
        AluCin  = 1'b0;
        merged  = stage;
        if (state == EXEC) begin
            AluMode = lat_mode;
            AluSel  = lat_sel;
            AluA    = lat_a[idx*8 +: 8];
            AluB    = lat_b[idx*8 +: 8];
            AluCin  = chain_carry;
            merged[idx*8 +: 8] = AluF;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            idx         <= '0;
            lat_mode    <= 1'b0;
            lat_sel     <= 4'h0;
            lat_a       <= '0;
            lat_b       <= '0;
            chain_carry <= 1'b0;
            stage       <= '0;
            F           <= '0;
            CarryOut    <= 1'b0;
            ZeroFlag    <= 1'b1;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        lat_mode    <= Mode;
                        lat_sel     <= Selector;
                        lat_a       <= A;
                        lat_b       <= B;
                        chain_carry <= CarryIn;
                        idx         <= '0;
                        stage       <= '0;
                        Busy        <= 1'b1;
                        state       <= EXEC;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                EXEC: begin
`ifdef ALU_WIDE_SEQ_ABORT_EN
                    if (Abort) begin
                        idx   <= '0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else
`endif
                    begin
                        stage       <= merged;
                        chain_carry <= AluCout;
                        // Final slice: publish the wide result and flags together with Done.
                        if (idx == LAST_IDX) begin
                            idx      <= '0;
                            F        <= merged;
                            CarryOut <= AluCout;
                            ZeroFlag <= (merged == '0);
                            Busy     <= 1'b0;
                            Done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq: a byte-level ALU model feeds the DUT,
// and results are compared against a whole-word arithmetic reference.
module tb_alu_wide_seq;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic         CLK;
    logic         RST;
    logic         Start;
    logic         Mode;
    logic [3:0]   Selector;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CarryIn;
    logic         Busy;
    logic         Done;
    logic [W-1:0] F;
    logic         CarryOut;
    logic         ZeroFlag;
    logic         AluMode;
    logic [3:0]   AluSel;
    logic [7:0]   AluA;
    logic [7:0]   AluB;
    logic         AluCin;
    logic [7:0]   AluF;
    logic         AluCout;
`ifdef ALU_WIDE_SEQ_ABORT_EN
    logic         Abort;
`endif

    int vectors;
    int miscompares;

    logic [W-1:0] exp_f;
    logic         exp_co;
    logic         exp_z;

    alu_wide_seq #(.NBYTES(NB)) dut (
        .CLK      (CLK),
        .RST      (RST),
`ifdef ALU_WIDE_SEQ_ABORT_EN
        .Abort    (Abort),
`endif
        .Start    (Start),
        .Mode     (Mode),
        .Selector (Selector),
        .A        (A),
        .B        (B),
        .CarryIn  (CarryIn),
        .Busy     (Busy),
        .Done     (Done),
        .F        (F),
        .CarryOut (CarryOut),
        .ZeroFlag (ZeroFlag),
        .AluMode  (AluMode),
        .AluSel   (AluSel),
        .AluA     (AluA),
        .AluB     (AluB),
        .AluCin   (AluCin),
        .AluF     (AluF),
        .AluCout  (AluCout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Combinational 8-bit ALU: arithmetic carries out, logic passes the carry through.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = 9'h000;
        AluF    = 8'h00;
        AluCout = 1'b0;
        if (!AluMode) begin
            case (AluSel)
                4'h1:    alu_sum = {1'b0, AluA} + {1'b0, ~AluB} + 9'(AluCin);
                4'h2:    alu_sum = {1'b0, AluA} + 9'(AluCin);
                4'h3:    alu_sum = {1'b0, AluA} + 9'h0FF + 9'(AluCin);
                default: alu_sum = {1'b0, AluA} + {1'b0, AluB} + 9'(AluCin);
            endcase
            AluF    = alu_sum[7:0];
            AluCout = alu_sum[8];
        end else begin
            case (AluSel)
                4'h0:    AluF = ~AluA;
                4'h3:    AluF = 8'h00;
                4'h6:    AluF = AluA ^ AluB;
                4'h8:    AluF = AluA & AluB;
                4'hE:    AluF = AluA | AluB;
                default: AluF = AluA;
            endcase
            AluCout = AluCin;
        end
    end

    // Whole-word reference: result, final carry, and the carry expected into each byte slice.
    function automatic void modelOp(input logic m, input logic [3:0] s,
                                    input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic c, output logic [W-1:0] f,
                                    output logic co, output logic [NB-1:0] cin_vec);
        logic [W:0]   sum;
        logic [W:0]   mask;
        logic [W:0]   part;
        logic [W-1:0] bx;
        if (!m) begin
            case (s)
                4'h1:    bx = ~b;
                4'h2:    bx = '0;
                4'h3:    bx = '1;
                default: bx = b;
            endcase
            sum = {1'b0, a} + {1'b0, bx} + (W+1)'(c);
            f   = sum[W-1:0];
            co  = sum[W];
            for (int k = 0; k < NB; k++) begin
                mask = ((W+1)'(1) << (8 * k)) - (W+1)'(1);
                part = ({1'b0, a} & mask) + ({1'b0, bx} & mask) + (W+1)'(c);
                cin_vec[k] = part[8 * k];
            end
        end else begin
            case (s)
                4'h0:    f = ~a;
                4'h3:    f = '0;
                4'h6:    f = a ^ b;
                4'h8:    f = a & b;
                4'hE:    f = a | b;
                default: f = a;
            endcase
            co      = c;
            cin_vec = {NB{c}};
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation: accept, scramble inputs, check every slice, then the Done cycle.
    task automatic applyStimulus(input logic m, input logic [3:0] s, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c);
        logic [W-1:0]  ef;
        logic          eco;
        logic [NB-1:0] ecin;
        modelOp(m, s, a, b, c, ef, eco, ecin);
        @(negedge CLK);
        Start = 1'b1; Mode = m; Selector = s; A = a; B = b; CarryIn = c;
        @(negedge CLK);
        Start = 1'b0; Mode = ~m; Selector = 4'($urandom);
        A = W'({$urandom, $urandom}); B = W'({$urandom, $urandom}); CarryIn = ~c;
        for (int k = 0; k < NB; k++) begin
            checkOutput($sformatf("busy_s%0d", k), 64'(Busy), 64'(1));
            checkOutput($sformatf("done_s%0d", k), 64'(Done), 64'(0));
            checkOutput($sformatf("alu_mode_s%0d", k), 64'(AluMode), 64'(m));
            checkOutput($sformatf("alu_sel_s%0d", k), 64'(AluSel), 64'(s));
            checkOutput($sformatf("alu_a_s%0d", k), 64'(AluA), 64'(a[8*k +: 8]));
            checkOutput($sformatf("alu_b_s%0d", k), 64'(AluB), 64'(b[8*k +: 8]));
            checkOutput($sformatf("alu_cin_s%0d", k), 64'(AluCin), 64'(ecin[k]));
            checkOutput($sformatf("f_hold_s%0d", k), 64'(F), 64'(exp_f));
            @(negedge CLK);
        end
        checkOutput("done_pulse", 64'(Done), 64'(1));
        checkOutput("done_busy", 64'(Busy), 64'(0));
        checkOutput("result_f", 64'(F), 64'(ef));
        checkOutput("result_cout", 64'(CarryOut), 64'(eco));
        checkOutput("result_zero", 64'(ZeroFlag), 64'(ef == '0));
        exp_f  = ef;
        exp_co = eco;
        exp_z  = (ef == '0);
        @(negedge CLK);
        checkOutput("done_drop", 64'(Done), 64'(0));
        checkOutput("f_after", 64'(F), 64'(exp_f));
    endtask

    int done_times[$];
    int done_cnt;

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST = 1'b1; Start = 1'b0; Mode = 1'b0; Selector = 4'h0;
        A = '0; B = '0; CarryIn = 1'b0;
`ifdef ALU_WIDE_SEQ_ABORT_EN
        Abort = 1'b0;
`endif
        exp_f = '0; exp_co = 1'b0; exp_z = 1'b1;
        #1;
        checkOutput("rst_busy", 64'(Busy), 64'(0));
        checkOutput("rst_done", 64'(Done), 64'(0));
        checkOutput("rst_f", 64'(F), 64'(0));
        checkOutput("rst_cout", 64'(CarryOut), 64'(0));
        checkOutput("rst_zero", 64'(ZeroFlag), 64'(1));
        checkOutput("rst_alu_mode", 64'(AluMode), 64'(1));
        checkOutput("rst_alu_sel", 64'(AluSel), 64'(0));
        checkOutput("rst_alu_a", 64'(AluA), 64'(0));
        checkOutput("rst_alu_b", 64'(AluB), 64'(0));
        checkOutput("rst_alu_cin", 64'(AluCin), 64'(0));
        @(negedge CLK);
        RST = 1'b0;

        $display("[TB] directed operations");
        applyStimulus(1'b1, 4'h6, 16'hF0F0, 16'h0FF0, 1'b0);
        applyStimulus(1'b0, 4'h0, 16'h00FF, 16'h0001, 1'b0);
        applyStimulus(1'b1, 4'h3, 16'hFFFF, 16'h1234, 1'b1);
        applyStimulus(1'b0, 4'h1, 16'h0000, 16'h0001, 1'b1);
        applyStimulus(1'b0, 4'h3, 16'h0100, 16'h0000, 1'b0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom), 4'($urandom), W'({$urandom, $urandom}),
                          W'({$urandom, $urandom}), 1'($urandom));
        end

        $display("[TB] back-to-back with Start held high");
        @(negedge CLK);
        Start = 1'b1; Mode = 1'b0; Selector = 4'h0; A = 16'h1234; B = 16'h4321; CarryIn = 1'b1;
        done_times.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (Done) done_times.push_back(i);
            if (i == 8) Start = 1'b0;
        end
        checkOutput("b2b_done_count", 64'(done_times.size()), 64'(3));
        if (done_times.size() == 3) begin
            checkOutput("b2b_gap0", 64'(done_times[1] - done_times[0]), 64'(NB + 1));
            checkOutput("b2b_gap1", 64'(done_times[2] - done_times[1]), 64'(NB + 1));
            checkOutput("b2b_first", 64'(done_times[0]), 64'(NB));
        end
        checkOutput("b2b_f", 64'(F), 64'(16'h5556));
        checkOutput("b2b_cout", 64'(CarryOut), 64'(0));
        exp_f = 16'h5556; exp_co = 1'b0; exp_z = 1'b0;

`ifdef ALU_WIDE_SEQ_ABORT_EN
        $display("[TB] abort in first slice");
        @(negedge CLK);
        Start = 1'b1; Mode = 1'b0; Selector = 4'h0; A = 16'h1111; B = 16'h2222; CarryIn = 1'b0;
        @(negedge CLK);
        Start = 1'b0; Abort = 1'b1;
        @(negedge CLK);
        Abort = 1'b0;
        checkOutput("abort_busy", 64'(Busy), 64'(0));
        checkOutput("abort_done", 64'(Done), 64'(0));
        checkOutput("abort_f", 64'(F), 64'(exp_f));
        checkOutput("abort_cout", 64'(CarryOut), 64'(exp_co));
        checkOutput("abort_zero", 64'(ZeroFlag), 64'(exp_z));
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (Done) done_cnt++;
        end
        checkOutput("abort_no_done", 64'(done_cnt), 64'(0));
        applyStimulus(1'b0, 4'h0, 16'h1111, 16'h2222, 1'b0);
`endif

        $display("[TB] reset during EXEC");
        @(negedge CLK);
        Start = 1'b1; Mode = 1'b0; Selector = 4'h0; A = 16'h00FF; B = 16'h0001; CarryIn = 1'b0;
        @(negedge CLK);
        Start = 1'b0;
        RST = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 64'(Busy), 64'(0));
        checkOutput("mid_rst_done", 64'(Done), 64'(0));
        checkOutput("mid_rst_f", 64'(F), 64'(0));
        checkOutput("mid_rst_zero", 64'(ZeroFlag), 64'(1));
        checkOutput("mid_rst_cout", 64'(CarryOut), 64'(0));
        checkOutput("mid_rst_alu_a", 64'(AluA), 64'(0));
        @(negedge CLK);
        RST = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (Done) done_cnt++;
        end
        checkOutput("mid_rst_no_done", 64'(done_cnt), 64'(0));
        checkOutput("mid_rst_idle", 64'(Busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
- Multi-byte operation sequencer placed directly upstream of the 8-bit ALU (Mode, Selector, A, B, CarryIn -> F, CarryOut, ZeroFlag).
- Accepts one NBYTES-wide operation per Start pulse and drives the ALU one byte per cycle, least-significant byte first.
- Chains each byte's CarryOut into the next byte's CarryIn and assembles the wide result and flags.
- Lets the 8-bit datapath execute 16-bit (or wider) ADD/SUB/INC/DEC/logic for the AY8 register pairs.

Parameters:
- NBYTES, 2, number of byte slices per operation (legal 2..8); W = 8*NBYTES.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Start  in  1  request; sampled only in IDLE or DONE.
- Mode  in  1  ALU mode (1 = logic, 0 = arithmetic), latched on accept.
- Selector  in  4  ALU function code, latched on accept.
- A  in  W  operand A, latched on accept.
- B  in  W  operand B, latched on accept.
- CarryIn  in  1  carry into byte 0, ALU polarity, latched on accept.
- Busy  out  1  high while slices are executing.
- Done  out  1  one-cycle pulse when result is valid.
- F  out  W  wide result, held until the next accept.
- CarryOut  out  1  CarryOut of the most-significant slice, ALU polarity.
- ZeroFlag  out  1  1 when F == 0.
- AluMode  out  1  to ALU Mode.
- AluSel  out  4  to ALU Selector.
- AluA  out  8  to ALU A.
- AluB  out  8  to ALU B.
- AluCin  out  1  to ALU CarryIn.
- AluF  in  8  from ALU F.
- AluCout  in  1  from ALU CarryOut.

Behaviour:
- Reset (RST=1, asynchronous):
  - State IDLE; Busy=0, Done=0, F=0, CarryOut=0, ZeroFlag=1.
  - AluMode=1, AluSel=0, AluA=0, AluB=0, AluCin=0.
  - Byte index idx=0. All latched operand registers cleared.
- States: IDLE, EXEC, DONE.
- IDLE or DONE with Start=1 at an edge:
  - Latch Mode, Selector, A, B, CarryIn. Set idx=0, chain carry = CarryIn.
  - Go to EXEC; Busy=1 from this edge.
  - F, CarryOut and ZeroFlag keep their old values until DONE.
- EXEC:
  - Combinationally drive AluMode/AluSel from the latched values, AluA/AluB from latched byte idx, AluCin from the chain carry.
  - Each edge: write AluF into F-staging byte idx, and set chain carry = AluCout (raw; no polarity inversion, since the ALU's own convention chains directly).
  - If idx == NBYTES-1, go to DONE; otherwise idx++.
  - The ALU is combinational, so exactly one slice completes per cycle.
- DONE:
  - On entry, the staging register is copied to F, CarryOut = final AluCout, ZeroFlag = (staged result == 0).
  - ZeroFlag is computed over all W bits; per-slice ALU ZeroFlag is not used.
  - Done=1 and Busy=0 for exactly one cycle.
  - Next edge: back to IDLE, or straight to EXEC if Start=1 (back-to-back operation).
- Latency: Start accepted at edge N; Done high in the cycle after edge N+NBYTES; throughput one operation per NBYTES+1 cycles.
- Start while in EXEC is ignored. It is not queued.
- Logic mode:
  - The carry chain still runs; the ALU's CarryOut passes through unchanged.
  - The wide CarryOut is therefore whatever the top slice returns.
- Operands may change after accept without affecting the operation in flight.
- Outputs are stable between Done pulses.
- RST asserted mid-EXEC: immediate return to IDLE with all reset values. The partial result is discarded; no Done pulse.

Optional Feature:
- Macro ALU_WIDE_SEQ_ABORT_EN.
- When defined:
  - Extra input port Abort (1 bit).
  - Abort=1 at an edge in EXEC returns the block to IDLE, clears Busy, gives no Done, and leaves F/CarryOut/ZeroFlag unchanged.
  - Abort has priority over slice completion.
  - Abort in IDLE or DONE has no effect; Start in DONE still accepts if Abort=0.
- When undefined: no Abort port; EXEC always runs to completion.

Test Plan:
- Reset: RST=1 mid-EXEC with NBYTES=2 -> next sample Busy=0, Done=0, F=16'h0000, ZeroFlag=1, and no Done pulse afterwards.
- Logic XOR: Mode=1, Selector=4'h6, A=16'hF0F0, B=16'h0FF0 -> Done at edge N+3 (cycle after N+2), F=16'hFF00, ZeroFlag=0, AluA sequence 8'hF0 then 8'hF0.
- Carry chain: Mode=0, Selector=ALU_ARITH_ADD, CarryIn=ALU_CARRY_OFF, A=16'h00FF, B=16'h0001 -> F=16'h0100. Byte-1 AluCin equals byte-0 AluCout.
- All-zero constant: Mode=1, Selector=4'h3, A=16'hFFFF -> F=16'h0000, ZeroFlag=1. CarryOut equals the value of CarryIn given to the ALU.
- Back-to-back: Start held high across Done -> second accept in the DONE cycle, Done pulses spaced exactly 3 cycles apart. Start during EXEC is ignored: Done count equals accept count.
- ALU_WIDE_SEQ_ABORT_EN: Abort=1 in the byte-0 cycle -> IDLE next edge, F keeps the previous result, no Done pulse.
